// File: rtl/div_seq.sv
// Sequential restoring divider: one quotient bit per clock, optional fractional bits.
// Handshaked in/out; quotient = floor(A*2^FRAC_BITS / B), remainder = (A*2^FRAC_BITS) mod B.
module div_seq #(
    parameter int WIDTH     = 12,
    parameter int FRAC_BITS = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           dividend,
    input  logic [WIDTH-1:0]           divisor,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH+FRAC_BITS-1:0] quotient,
    output logic [WIDTH-1:0]           remainder,
    output logic                       inv
);
    localparam int QW = WIDTH + FRAC_BITS;
    localparam int CW = (QW > 1) ? $clog2(QW) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_b;
    logic [QW-1:0]    r_shift;
    logic [WIDTH:0]   r_part;
    logic [QW-1:0]    r_quo;
    logic [WIDTH-1:0] r_rem;
    logic             r_inv;
    logic             r_out_valid;
    logic             r_in_ready;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH:0]   w_next_part;

    // The dividend (padded with FRAC_BITS zeros) leaves r_shift MSB first.
    assign w_shifted   = {r_part[WIDTH-1:0], r_shift[QW-1]};
    assign w_diff      = w_shifted - {1'b0, r_b};
    assign w_ge        = (w_shifted >= {1'b0, r_b});
    assign w_next_part = w_ge ? w_diff : w_shifted;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_b         <= '0;
            r_shift     <= '0;
            r_part      <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_inv       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_b        <= divisor;
                        r_shift    <= QW'(dividend) << FRAC_BITS;
                        r_part     <= '0;
                        r_cnt      <= CW'(QW - 1);
                        r_in_ready <= 1'b0;
                        if (divisor == '0) begin
                            r_quo       <= '1;
                            r_rem       <= dividend;
                            r_inv       <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_quo   <= '0;
                            r_inv   <= 1'b0;
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    r_shift <= r_shift << 1;
                    r_part  <= w_next_part;
                    r_quo   <= {r_quo[QW-2:0], w_ge};
                    if (r_cnt == '0) begin
                        r_rem       <= w_next_part[WIDTH-1:0];
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign quotient  = r_quo;
    assign remainder = r_rem;
    assign inv       = r_inv;
endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: one instance with FRAC_BITS=0, one with FRAC_BITS=4.
// Stimulus pushes hand-computed expectations; per-instance monitors pop on each drained result.
module tb_div_seq;
    typedef struct {
        logic [15:0] q;
        logic [11:0] r;
        logic        inv;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        iv0 = 1'b0, ir0, ov0, or0 = 1'b1, inv0;
    logic [11:0] a0 = '0, b0 = '0, q0, r0;
    logic        iv4 = 1'b0, ir4, ov4, or4 = 1'b1, inv4;
    logic [11:0] a4 = '0, b4 = '0, r4;
    logic [15:0] q4;

    exp_t sb0[$];
    exp_t sb4[$];
    int   errors = 0;
    int   checks = 0;
    bit   randOr = 1'b0;

    always #5 clk = ~clk;

    div_seq #(.WIDTH(12), .FRAC_BITS(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0),
        .dividend(a0), .divisor(b0), .out_valid(ov0), .out_ready(or0),
        .quotient(q0), .remainder(r0), .inv(inv0)
    );

    div_seq #(.WIDTH(12), .FRAC_BITS(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
        .dividend(a4), .divisor(b4), .out_valid(ov4), .out_ready(or4),
        .quotient(q4), .remainder(r4), .inv(inv4)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Golden reference straight from the arithmetic definition.
    function automatic exp_t golden(input logic [11:0] a, input logic [11:0] b, input int f);
        exp_t e;
        int   num;
        num = int'(a) << f;
        if (b == 0) begin
            e.q   = (f == 0) ? 16'h0FFF : 16'hFFFF;
            e.r   = a;
            e.inv = 1'b1;
        end else begin
            e.q   = 16'(num / int'(b));
            e.r   = 12'(num % int'(b));
            e.inv = 1'b0;
        end
        return e;
    endfunction

    // Drive one operation and push its expected result once the accept edge is certain.
    task automatic applyStimulus(input bit sel, input logic [11:0] a, input logic [11:0] b,
                                 input logic [15:0] eq, input logic [11:0] er, input logic ei);
        int   n;
        exp_t e;
        n = 0;
        e.q = eq; e.r = er; e.inv = ei;
        @(posedge clk); #1;
        if (sel) begin a4 = a; b4 = b; iv4 = 1'b1; end
        else     begin a0 = a; b0 = b; iv0 = 1'b1; end
        forever begin
            @(negedge clk);
            if ((sel ? ir4 : ir0) === 1'b1) break;
            n++;
            if (n > 500) begin
                checkOutput("accept timeout", 32'(n), 0);
                break;
            end
        end
        if (sel) sb4.push_back(e); else sb0.push_back(e);
        @(posedge clk); #1;
        if (sel) begin iv4 = 1'b0; a4 = 12'($urandom); b4 = 12'($urandom); end
        else     begin iv0 = 1'b0; a0 = 12'($urandom); b0 = 12'($urandom); end
    endtask

    // Counts clock edges after the accept edge until out_valid is seen.
    task automatic waitValid(input bit sel, output int lat);
        lat = 0;
        while ((sel ? ov4 : ov0) !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 200) checkOutput("out_valid timeout", 32'(lat), 0);
    endtask

    always @(negedge clk) begin : monitor0
        exp_t e;
        if (!rst && ov0 && or0) begin
            if (sb0.size() == 0) begin
                checkOutput("dut0 unexpected result", 32'(q0), 32'hFFFF_FFFF);
            end else begin
                e = sb0.pop_front();
                checkOutput("dut0 quotient", 32'(q0), 32'(e.q[11:0]));
                checkOutput("dut0 remainder", 32'(r0), 32'(e.r));
                checkOutput("dut0 inv", 32'(inv0), 32'(e.inv));
            end
        end
    end

    always @(negedge clk) begin : monitor4
        exp_t e;
        if (!rst && ov4 && or4) begin
            if (sb4.size() == 0) begin
                checkOutput("dut4 unexpected result", 32'(q4), 32'hFFFF_FFFF);
            end else begin
                e = sb4.pop_front();
                checkOutput("dut4 quotient", 32'(q4), 32'(e.q));
                checkOutput("dut4 remainder", 32'(r4), 32'(e.r));
                checkOutput("dut4 inv", 32'(inv4), 32'(e.inv));
            end
        end
    end

    // Random consumer backpressure, changed away from the sampling edge.
    always @(posedge clk) begin
        if (randOr) begin
            #1;
            or0 = 1'($urandom_range(0, 1));
            or4 = 1'($urandom_range(0, 1));
        end
    end

    initial begin : stimulus
        int          lat;
        int          n;
        logic [11:0] a;
        logic [11:0] b;
        exp_t        e;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset in_ready", 32'(ir0), 1);
        checkOutput("reset out_valid", 32'(ov0), 0);
        checkOutput("reset quotient", 32'(q0), 0);
        checkOutput("reset remainder", 32'(r0), 0);
        checkOutput("reset inv", 32'(inv0), 0);
        rst = 1'b0;

        // 100/7 = 14 r 2; pulses on in_valid while busy must be ignored.
        applyStimulus(0, 12'd100, 12'd7, 16'd14, 12'd2, 1'b0);
        fork
            begin
                iv0 = 1'b1; a0 = 12'd1; b0 = 12'd1;
                repeat (4) @(posedge clk);
                #1 iv0 = 1'b0;
            end
        join_none
        waitValid(0, lat);
        checkOutput("latency 100/7 QW=12", 32'(lat), 12);

        // 1600/7 = 228 r 4 with four fractional bits.
        applyStimulus(1, 12'd100, 12'd7, 16'd228, 12'd4, 1'b0);
        waitValid(1, lat);
        checkOutput("latency 100/7 QW=16", 32'(lat), 16);
        applyStimulus(1, 12'd4095, 12'd1, 16'hFFF0, 12'd0, 1'b0);
        applyStimulus(1, 12'd9, 12'd0, 16'hFFFF, 12'd9, 1'b1);

        // Divide by zero: result visible in the first cycle after the accept edge.
        applyStimulus(0, 12'd55, 12'd0, 16'h0FFF, 12'd55, 1'b1);
        checkOutput("div0 out_valid after accept", 32'(ov0), 1);

        // Backpressure: result held stable, no new accept while undrained.
        @(posedge clk); #1 or0 = 1'b0;
        applyStimulus(0, 12'd5, 12'd9, 16'd0, 12'd5, 1'b0);
        waitValid(0, lat);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("hold quotient", 32'(q0), 0);
            checkOutput("hold remainder", 32'(r0), 5);
            checkOutput("hold out_valid", 32'(ov0), 1);
            checkOutput("hold in_ready", 32'(ir0), 0);
        end
        @(posedge clk); #1 or0 = 1'b1;
        @(posedge clk); #1;
        checkOutput("drain out_valid", 32'(ov0), 0);
        checkOutput("drain in_ready", 32'(ir0), 1);

        // Reset in the middle of an operation aborts it.
        applyStimulus(0, 12'd3000, 12'd3, 16'd1000, 12'd0, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort out_valid", 32'(ov0), 0);
        checkOutput("abort in_ready", 32'(ir0), 1);
        checkOutput("abort quotient", 32'(q0), 0);
        checkOutput("abort remainder", 32'(r0), 0);
        rst = 1'b0;
        sb0.delete();
        sb4.delete();
        applyStimulus(0, 12'd3000, 12'd3, 16'd1000, 12'd0, 1'b0);
        applyStimulus(0, 12'd4095, 12'd4095, 16'd1, 12'd0, 1'b0);
        applyStimulus(0, 12'd4094, 12'd4095, 16'd0, 12'd4094, 1'b0);
        applyStimulus(0, 12'd4095, 12'd1, 16'd4095, 12'd0, 1'b0);

        // Short sweep against the golden arithmetic with random backpressure.
        randOr = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a = 12'($urandom_range(0, 4095));
            b = (i % 8 == 0) ? 12'd0 :
                (i % 3 == 0) ? 12'($urandom_range(1, 15)) : 12'($urandom_range(1, 4095));
            e = golden(a, b, 0);
            applyStimulus(0, a, b, e.q, e.r, e.inv);
            e = golden(a, b, 4);
            applyStimulus(1, a, b, e.q, e.r, e.inv);
        end
        randOr = 1'b0;
        @(posedge clk); #1;
        or0 = 1'b1;
        or4 = 1'b1;

        n = 0;
        while ((sb0.size() != 0 || sb4.size() != 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        checkOutput("scoreboard drained", 32'(sb0.size() + sb4.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
